// File: rtl/pkt_out_buffer.sv
// Dispatcher-side packet buffer: data + keep/drop FIFOs, forwards kept packets.
// Optional macro OB_PKT_CNT_EN adds sent/drop packet counters.
module pkt_out_buffer #(
  parameter int DATA_AW    = 9,
  parameter int VAL_AW     = 5,
  parameter int ALF_MARGIN = 100
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         disp2ob_data_wr,
  input  logic [133:0] disp2ob_data,
  input  logic         disp2ob_valid_wr,
  input  logic         disp2ob_valid,
  output logic         ob2disp_alf,
  output logic         ob2tx_data_wr,
  output logic [133:0] ob2tx_data,
  output logic         ob2tx_valid_wr,
  output logic         ob2tx_valid,
  input  logic         tx2ob_alf,
  output logic         ob_err_ovf
`ifdef OB_PKT_CNT_EN
  ,
  output logic [31:0]  ob_pkt_sent_cnt,
  output logic [31:0]  ob_pkt_drop_cnt
`endif
);

  localparam int DDEPTH = 1 << DATA_AW;
  localparam int VDEPTH = 1 << VAL_AW;

  localparam logic [DATA_AW-1:0] C_DP1   = DATA_AW'(1);
  localparam logic [DATA_AW:0]   C_DU1   = (DATA_AW+1)'(1);
  localparam logic [DATA_AW:0]   C_DFULL = (DATA_AW+1)'(DDEPTH);
  localparam logic [DATA_AW:0]   C_DTHR  = (DATA_AW+1)'(DDEPTH - ALF_MARGIN);
  localparam logic [VAL_AW-1:0]  C_VP1   = VAL_AW'(1);
  localparam logic [VAL_AW:0]    C_VU1   = (VAL_AW+1)'(1);
  localparam logic [VAL_AW:0]    C_VFULL = (VAL_AW+1)'(VDEPTH);
  localparam logic [VAL_AW:0]    C_VTHR  = (VAL_AW+1)'(VDEPTH - 2);

  typedef enum logic [1:0] {
    IDLE_S,
    SEND_S,
    DROP_S
  } state_t;

  logic [133:0]       r_dmem [DDEPTH];
  logic               r_tmem [DDEPTH];
  logic               r_vmem [VDEPTH];

  logic [DATA_AW-1:0] r_dwr_ptr;
  logic [DATA_AW-1:0] r_drd_ptr;
  logic [DATA_AW:0]   r_d_used;
  logic [VAL_AW-1:0]  r_vwr_ptr;
  logic [VAL_AW-1:0]  r_vrd_ptr;
  logic [VAL_AW:0]    r_v_used;

  state_t             r_state;
  logic [133:0]       r_q;
  logic               r_q_send;
  logic               r_q_tail;

  logic               w_d_full;
  logic               w_d_empty;
  logic               w_v_full;
  logic               w_v_empty;
  logic               w_d_wr;
  logic               w_v_wr;
  logic               w_d_rd;
  logic               w_v_rd;
  logic               w_v_flag;
  logic               w_tail;
  logic               w_busy;

  assign w_d_full  = (r_d_used == C_DFULL);
  assign w_d_empty = (r_d_used == '0);
  assign w_v_full  = (r_v_used == C_VFULL);
  assign w_v_empty = (r_v_used == '0);
  assign w_d_wr    = disp2ob_data_wr && !w_d_full;
  assign w_v_wr    = disp2ob_valid_wr && !w_v_full;
  assign w_busy    = (r_state != IDLE_S);
  assign w_d_rd    = w_busy && !w_d_empty;
  assign w_v_rd    = !w_busy && !w_v_empty && !tx2ob_alf;
  assign w_v_flag  = r_vmem[r_vrd_ptr];
  // Tail flag kept beside the RAM so the FSM stops on the tail it reads.
  assign w_tail    = r_tmem[r_drd_ptr];

  always_ff @(posedge clk) begin
    if (w_d_wr) begin
      r_dmem[r_dwr_ptr] <= disp2ob_data;
      r_tmem[r_dwr_ptr] <= (disp2ob_data[133:132] == 2'b10);
    end
    if (w_v_wr) begin
      r_vmem[r_vwr_ptr] <= disp2ob_valid;
    end
    if (w_d_rd) begin
      r_q <= r_dmem[r_drd_ptr];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_dwr_ptr   <= '0;
      r_drd_ptr   <= '0;
      r_d_used    <= '0;
      r_vwr_ptr   <= '0;
      r_vrd_ptr   <= '0;
      r_v_used    <= '0;
      ob2disp_alf <= 1'b0;
      ob_err_ovf  <= 1'b0;
    end else begin
      if (w_d_wr) r_dwr_ptr <= r_dwr_ptr + C_DP1;
      if (w_d_rd) r_drd_ptr <= r_drd_ptr + C_DP1;
      if (w_v_wr) r_vwr_ptr <= r_vwr_ptr + C_VP1;
      if (w_v_rd) r_vrd_ptr <= r_vrd_ptr + C_VP1;
      unique case ({w_d_wr, w_d_rd})
        2'b10:   r_d_used <= r_d_used + C_DU1;
        2'b01:   r_d_used <= r_d_used - C_DU1;
        default: ;
      endcase
      unique case ({w_v_wr, w_v_rd})
        2'b10:   r_v_used <= r_v_used + C_VU1;
        2'b01:   r_v_used <= r_v_used - C_VU1;
        default: ;
      endcase
      ob2disp_alf <= (r_d_used >= C_DTHR) || (r_v_used >= C_VTHR);
      ob_err_ovf  <= ob_err_ovf
                   || (disp2ob_data_wr && w_d_full)
                   || (disp2ob_valid_wr && w_v_full)
                   || (w_busy && w_d_empty);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state        <= IDLE_S;
      r_q_send       <= 1'b0;
      r_q_tail       <= 1'b0;
      ob2tx_data_wr  <= 1'b0;
      ob2tx_data     <= '0;
      ob2tx_valid_wr <= 1'b0;
      ob2tx_valid    <= 1'b0;
    end else begin
      r_q_send       <= w_d_rd && (r_state == SEND_S);
      r_q_tail       <= w_d_rd && w_tail;
      ob2tx_data_wr  <= r_q_send;
      ob2tx_valid_wr <= r_q_send && r_q_tail;
      ob2tx_valid    <= r_q_send && r_q_tail;
      if (r_q_send) ob2tx_data <= r_q;
      unique case (r_state)
        IDLE_S: begin
          if (w_v_rd) r_state <= w_v_flag ? SEND_S : DROP_S;
        end
        SEND_S, DROP_S: begin
          if (w_d_rd && w_tail) r_state <= IDLE_S;
        end
        default: r_state <= IDLE_S;
      endcase
    end
  end

`ifdef OB_PKT_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ob_pkt_sent_cnt <= '0;
      ob_pkt_drop_cnt <= '0;
    end else if (w_v_rd) begin
      if (w_v_flag) ob_pkt_sent_cnt <= ob_pkt_sent_cnt + 32'd1;
      else          ob_pkt_drop_cnt <= ob_pkt_drop_cnt + 32'd1;
    end
  end
`endif

endmodule
